// File: rtl/mips_multicycle_cpu.sv
// Multicycle MIPS subset (add/sub/and/or/slt, lw/sw, beq/bne, addi, j/jal) sharing one req/ready memory port.
// 3-5 cycles per instruction with mem_ready high; a cycle without mem_ready stalls the FSM with the request held stable.
module mips_multicycle_cpu #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [4:0]  LINK_REG        = 5'd31,
  parameter int          TRAP_ON_ILLEGAL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [4:0]  register_a1,
  output logic [4:0]  register_a2,
  output logic [4:0]  register_a3,
  output logic        register_we3,
  output logic [31:0] register_wd3,
  input  logic [31:0] register_rd1,
  input  logic [31:0] register_rd2,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sign_imm, alu_res, pc_plus4;
  logic        funct_ok, illegal, req_int;

  assign op          = ir_q[31:26];
  assign rs          = ir_q[25:21];
  assign rt          = ir_q[20:16];
  assign rd          = ir_q[15:11];
  assign funct       = ir_q[5:0];
  assign sign_imm    = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_plus4    = pc_q + 32'd4;
  assign funct_ok    = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  assign register_a1 = rs;
  assign register_a2 = rt;
  assign pc          = pc_q;
  assign halted      = (state_q == S_HALT);
  // FETCH is the reset state, so the request is masked while reset is held.
  assign mem_req     = req_int & rst_n;

  always_comb begin
    case (funct)
      FN_SUB:  alu_res = a_q - b_q;
      FN_AND:  alu_res = a_q & b_q;
      FN_OR:   alu_res = a_q | b_q;
      FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
      default: alu_res = a_q + b_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    mdr_d        = mdr_q;
    a_d          = a_q;
    b_d          = b_q;
    alu_out_d    = alu_out_q;
    req_int      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = pc_q;
    mem_wdata    = b_q;
    register_we3 = 1'b0;
    register_a3  = rt;
    register_wd3 = alu_out_q;
    retire       = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_int = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_plus4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d       = register_rd1;
        b_d       = register_rd2;
        alu_out_d = pc_q + {sign_imm[29:0], 2'b00};
        case (op)
          OP_RTYPE:     if (funct_ok) state_d = S_EXEC; else illegal = 1'b1;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J, OP_JAL: state_d = S_JUMP;
          default:      illegal = 1'b1;
        endcase
        // Without trapping, an undefined instruction retires here as a two-cycle nop.
        if (illegal) begin
          if (TRAP_ON_ILLEGAL != 0) begin
            state_d = S_HALT;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_MEMADR: begin
        alu_out_d = a_q + sign_imm;
        state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        req_int  = 1'b1;
        mem_addr = alu_out_q;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        register_we3 = 1'b1;
        register_wd3 = mdr_q;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        req_int  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = alu_out_q;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_out_d = alu_res;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        register_we3 = 1'b1;
        register_a3  = rd;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        alu_out_d = a_q + sign_imm;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        register_we3 = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        if ((a_q == b_q) == (op == OP_BEQ)) pc_d = alu_out_q;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        // pc_q already holds the return address (instr + 4) for the link write.
        pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
        if (op == OP_JAL) begin
          register_we3 = 1'b1;
          register_a3  = LINK_REG;
          register_wd3 = pc_q;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      mdr_q     <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_out_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Bench for mips_multicycle_cpu: program table loaded into a bench memory, expected retirements queued and checked on each retire pulse.
module tb_mips_multicycle_cpu;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        ret;
    int          cycles;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] pc_after;
  } vec_t;

  logic        clk, rst_n;
  logic [31:0] pc, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [4:0]  register_a1, register_a2, register_a3;
  logic        register_we3, retire, halted;
  logic [31:0] register_wd3, register_rd1, register_rd2;

  logic [31:0] mem [256];
  logic [31:0] rf  [32];
  vec_t        vecs [20];
  vec_t        expq [$];
  logic        tbl_loaded, stall;
  int          checks, errors;

  mips_multicycle_cpu dut (
    .clk(clk), .rst_n(rst_n), .pc(pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .register_a1(register_a1), .register_a2(register_a2), .register_a3(register_a3),
    .register_we3(register_we3), .register_wd3(register_wd3),
    .register_rd1(register_rd1), .register_rd2(register_rd2),
    .retire(retire), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] f_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  // Wait cycles inserted before mem_ready for particular addresses.
  function automatic int mem_delay(input logic [31:0] a);
    case (a)
      32'h0000_03FC: return 3;
      32'h0000_000C: return 1;
      default:       return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Register file: combinational read, write on the rising edge, $0 reads as zero.
  assign register_rd1 = (register_a1 == 5'd0) ? 32'd0 : rf[register_a1];
  assign register_rd2 = (register_a2 == 5'd0) ? 32'd0 : rf[register_a2];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    forever begin
      @(posedge clk);
      if (register_we3 && register_a3 != 5'd0) rf[register_a3] = register_wd3;
    end
  end

  // Memory responder: ready/rdata settle 2 time units after each rising edge.
  initial begin
    int w;
    logic [7:0] idx;
    w = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    wait (tbl_loaded);
    for (int i = 0; i < 20; i++) mem[vecs[i].addr[9:2]] = vecs[i].instr;
    mem[255] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #2;
      idx = mem_addr[9:2];
      if (mem_req && !stall) begin
        if (w >= mem_delay(mem_addr)) begin
          mem_ready = 1'b1;
          mem_rdata = mem[idx];
          if (mem_we) mem[idx] = mem_wdata;
          w = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hBAD0_BAD0;
          w++;
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        w = 0;
      end
    end
  end

  initial begin
    vec_t        e;
    int          n, cyc;
    logic        pend, p_req, p_rdy, p_we;
    logic [31:0] pend_pc, p_addr, p_wd;
    checks = 0; errors = 0;
    rst_n = 1'b0; stall = 1'b0; tbl_loaded = 1'b0;

    // addr, instr, retires, cycles, we3, a3, wd3, pc after
    vecs[0]  = '{32'h000, f_i(6'h08, 5'd0, 5'd1, 16'h0005), 1'b1, 4, 1'b1, 5'd1, 32'h5, 32'h004};
    vecs[1]  = '{32'h004, f_i(6'h08, 5'd1, 5'd1, 16'hFFFF), 1'b1, 4, 1'b1, 5'd1, 32'h4, 32'h008};
    vecs[2]  = '{32'h008, f_i(6'h23, 5'd1, 5'd2, 16'h03F8), 1'b1, 8, 1'b1, 5'd2, 32'hDEAD_BEEF, 32'h00C};
    vecs[3]  = '{32'h00C, f_i(6'h08, 5'd0, 5'd3, 16'h1234), 1'b1, 5, 1'b1, 5'd3, 32'h1234, 32'h010};
    vecs[4]  = '{32'h010, f_i(6'h2B, 5'd0, 5'd3, 16'h0000), 1'b1, 4, 1'b0, 5'd0, 32'h0, 32'h014};
    vecs[5]  = '{32'h014, f_i(6'h04, 5'd1, 5'd2, 16'h0005), 1'b1, 3, 1'b0, 5'd0, 32'h0, 32'h018};
    vecs[6]  = '{32'h018, f_i(6'h05, 5'd1, 5'd2, 16'h0002), 1'b1, 3, 1'b0, 5'd0, 32'h0, 32'h024};
    vecs[7]  = '{32'h024, f_r(5'd3, 5'd1, 5'd4, 6'h22), 1'b1, 4, 1'b1, 5'd4, 32'h1230, 32'h028};
    vecs[8]  = '{32'h028, f_r(5'd2, 5'd1, 5'd5, 6'h2A), 1'b1, 4, 1'b1, 5'd5, 32'h1, 32'h02C};
    vecs[9]  = '{32'h02C, f_r(5'd1, 5'd2, 5'd6, 6'h2A), 1'b1, 4, 1'b1, 5'd6, 32'h0, 32'h030};
    vecs[10] = '{32'h030, f_r(5'd2, 5'd3, 5'd7, 6'h24), 1'b1, 4, 1'b1, 5'd7, 32'h1224, 32'h034};
    vecs[11] = '{32'h034, f_r(5'd1, 5'd5, 5'd8, 6'h25), 1'b1, 4, 1'b1, 5'd8, 32'h5, 32'h038};
    vecs[12] = '{32'h038, f_r(5'd2, 5'd2, 5'd9, 6'h20), 1'b1, 4, 1'b1, 5'd9, 32'hBD5B_7DDE, 32'h03C};
    vecs[13] = '{32'h03C, f_i(6'h04, 5'd0, 5'd0, 16'h0031), 1'b1, 3, 1'b0, 5'd0, 32'h0, 32'h104};
    vecs[14] = '{32'h104, f_i(6'h04, 5'd0, 5'd0, 16'hFFFE), 1'b1, 3, 1'b0, 5'd0, 32'h0, 32'h100};
    vecs[15] = '{32'h100, f_j(6'h03, 26'h50), 1'b1, 3, 1'b1, 5'd31, 32'h104, 32'h140};
    vecs[16] = '{32'h140, f_i(6'h05, 5'd1, 5'd1, 16'h0005), 1'b1, 3, 1'b0, 5'd0, 32'h0, 32'h144};
    vecs[17] = '{32'h144, f_j(6'h02, 26'h60), 1'b1, 3, 1'b0, 5'd0, 32'h0, 32'h180};
    vecs[18] = '{32'h180, f_i(6'h08, 5'd0, 5'd0, 16'h0007), 1'b1, 4, 1'b1, 5'd0, 32'h7, 32'h184};
    vecs[19] = '{32'h184, 32'hFC00_0000, 1'b0, 0, 1'b0, 5'd0, 32'h0, 32'h0};
    tbl_loaded = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    chk("reset_retire", 32'(retire), 32'h0);
    chk("reset_we3", 32'(register_we3), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);

    for (int i = 0; i < 20; i++) if (vecs[i].ret) expq.push_back(vecs[i]);

    @(posedge clk); #1 rst_n = 1'b1;
    n = 0; cyc = 0; pend = 1'b0; pend_pc = 32'h0;
    p_req = 1'b0; p_rdy = 1'b0; p_we = 1'b0; p_addr = 32'h0; p_wd = 32'h0;
    while (!halted && n < 2000) begin
      @(negedge clk);
      n++; cyc++;
      if (pend) begin
        chk("pc_after", pc, pend_pc);
        pend = 1'b0;
      end
      if (p_req && !p_rdy) begin
        chk("req_hold", 32'(mem_req), 32'h1);
        chk("addr_hold", mem_addr, p_addr);
        chk("we_hold", 32'(mem_we), 32'(p_we));
        chk("wdata_hold", mem_wdata, p_wd);
      end
      if (register_we3) chk("we3_only_on_retire", 32'(retire), 32'h1);
      if (retire) begin
        chk("retire_expected", 32'(expq.size() != 0), 32'h1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk($sformatf("cycles@%h", e.addr), 32'(cyc), 32'(e.cycles));
          chk($sformatf("we3@%h", e.addr), 32'(register_we3), 32'(e.we3));
          if (e.we3) begin
            chk($sformatf("a3@%h", e.addr), 32'(register_a3), 32'(e.a3));
            chk($sformatf("wd3@%h", e.addr), register_wd3, e.wd3);
          end
          pend = 1'b1;
          pend_pc = e.pc_after;
        end
        cyc = 0;
      end
      p_req = mem_req; p_rdy = mem_ready; p_we = mem_we; p_addr = mem_addr; p_wd = mem_wdata;
    end

    chk("halt_reached", 32'(halted), 32'h1);
    chk("all_retired", 32'(expq.size()), 32'h0);
    chk("halt_pc", pc, 32'h188);
    chk("sw_stored", mem[0], 32'h1234);
    chk("link_reg", rf[31], 32'h104);
    chk("add_wrap_reg", rf[9], 32'hBD5B_7DDE);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("halt_quiet", {28'd0, mem_req, register_we3, retire, halted}, 32'h1);
    end

    // Reset clears the halt; mem[0] now holds an R-type with an undefined funct.
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_clears_halt", 32'(halted), 32'h0);
    chk("rst_pc", pc, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("illegal_funct_halt", 32'(halted), 32'h1);
    chk("illegal_funct_pc", pc, 32'h4);
    chk("illegal_no_retire", 32'(retire), 32'h0);

    // Fetch stalled by mem_ready=0, then reset in the middle of it.
    stall = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_halted", 32'(halted), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stalled_fetch", {mem_addr[29:0], mem_req, mem_we}, 32'h2);
    end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_fetch_req", 32'(mem_req), 32'h0);
    chk("rst_mid_fetch_pc", pc, 32'h0);
    chk("rst_mid_fetch_halted", 32'(halted), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
